// File: rtl/mem_io_bus_pkg.sv
// Shared types and helpers for the mem_io_bus address decoder and handshake FSM.
package mem_io_bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAM_ACC  = 2'd1,
    PER_WAIT = 2'd2,
    RESP     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    REG_RAM      = 2'd0,
    REG_PERIPH   = 2'd1,
    REG_UNMAPPED = 2'd2
  } region_e;

  // Default memory map: RAM at the bottom, peripheral windows from 0x800 upward.
  localparam int unsigned DEF_RAM_DEPTH    = 1024;
  localparam int unsigned DEF_PERIPH_BASE  = 2048;
  localparam int unsigned DEF_PERIPH_DEPTH = 64;
  localparam int unsigned DEF_N_PERIPH     = 4;

  // Bits needed to index 'value' entries; never less than one.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned width = 1;
    while ((32'd1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/mem_io_bus_data_ram.sv
// Single-port data RAM with synchronous read; read data holds until the next enabled read.
module data_ram
  import mem_io_bus_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned RAM_DEPTH = DEF_RAM_DEPTH,
  parameter string       INIT_FILE = ""
) (
  input  logic                         i_clk,
  input  logic                         i_en,
  input  logic                         i_we,
  input  logic [clogb2(RAM_DEPTH)-1:0] i_addr,
  input  logic [DATA_W-1:0]            i_wdata,
  output logic [DATA_W-1:0]            o_rdata
);

  logic [DATA_W-1:0] mem_q [RAM_DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array and its read register carry no reset so the tools can map them to block RAM,
  // and so that contents survive a bus reset.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) mem_q[i_addr] <= i_wdata;
      else      rdata_q       <= mem_q[i_addr];
    end
  end

  assign o_rdata = rdata_q;

  if (INIT_FILE != "") begin : g_init_unsupported
    $warning("data_ram: INIT_FILE preload is not applied by this RAM; contents start undefined");
  end

endmodule

// File: rtl/mem_io_bus.sv
// CPU data-port decoder: internal RAM plus N_PERIPH peripheral windows behind a
// request/ready handshake with per-peripheral ack and a wait timeout.
module mem_io_bus
  import mem_io_bus_pkg::*;
#(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned RAM_DEPTH    = DEF_RAM_DEPTH,
  parameter int unsigned N_PERIPH     = DEF_N_PERIPH,
  parameter int unsigned PERIPH_DEPTH = DEF_PERIPH_DEPTH,
  parameter int unsigned PERIPH_BASE  = DEF_PERIPH_BASE,
  parameter int unsigned TIMEOUT      = 15,
  parameter string       INIT_FILE    = ""
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [ADDR_W-1:0]               i_addr,
  input  logic [DATA_W-1:0]               i_data,
  input  logic                            i_wr,
  input  logic                            i_rd,
  output logic [DATA_W-1:0]               o_data,
  output logic                            o_ready,
  output logic                            o_bus_err,
  output logic [N_PERIPH-1:0]             o_cs_perif,
  output logic [clogb2(PERIPH_DEPTH)-1:0] o_addr_bus,
  output logic [DATA_W-1:0]               o_data_perif,
  output logic                            o_wr_perif,
  output logic                            o_rd_perif,
  input  logic [N_PERIPH*DATA_W-1:0]      i_data_perif,
  input  logic [N_PERIPH-1:0]             i_ack_perif
);

  localparam int unsigned RAM_AW        = clogb2(RAM_DEPTH);
  localparam int unsigned PA_W          = clogb2(PERIPH_DEPTH);
  localparam int unsigned IDX_W         = 32 - PA_W;
  localparam int unsigned CNT_W         = clogb2(TIMEOUT + 1);
  localparam logic [31:0] RAM_LIMIT     = 32'(RAM_DEPTH);
  localparam logic [31:0] PER_BASE      = 32'(PERIPH_BASE);
  localparam bit          TIMEOUT_EN    = (TIMEOUT != 0);

  if (RAM_DEPTH > PERIPH_BASE) begin : g_overlap
    $error("mem_io_bus: RAM region overlaps peripheral window 0");
  end
  if (N_PERIPH < 1 || N_PERIPH > 8) begin : g_nperiph
    $error("mem_io_bus: N_PERIPH must be in 1..8");
  end

  // ---------------- address decode ----------------
  logic [31:0]         addr_ext;
  logic [31:0]         per_off;
  logic [IDX_W-1:0]    win_idx;
  region_e             dec_region;
  logic [N_PERIPH-1:0] dec_cs;

  always_comb begin
    addr_ext   = 32'(i_addr);
    per_off    = addr_ext - PER_BASE;
    win_idx    = per_off[31:PA_W];
    dec_region = REG_UNMAPPED;
    dec_cs     = '0;
    if (addr_ext < RAM_LIMIT) begin
      dec_region = REG_RAM;
    end else if (addr_ext >= PER_BASE && win_idx < IDX_W'(N_PERIPH)) begin
      dec_region = REG_PERIPH;
      dec_cs     = N_PERIPH'(1) << win_idx;
    end
  end

  // ---------------- state ----------------
  state_e              state_q,      state_d;
  region_e             region_q,     region_d;
  logic                wr_q,         wr_d;
  logic                err_q,        err_d;
  logic [RAM_AW-1:0]   ram_addr_q,   ram_addr_d;
  logic [DATA_W-1:0]   wdata_q,      wdata_d;
  logic [DATA_W-1:0]   pdata_q,      pdata_d;
  logic [CNT_W-1:0]    cnt_q,        cnt_d;
  logic [N_PERIPH-1:0] cs_q,         cs_d;
  logic [PA_W-1:0]     addr_bus_q,   addr_bus_d;
  logic [DATA_W-1:0]   data_perif_q, data_perif_d;
  logic                wr_perif_q,   wr_perif_d;
  logic                rd_perif_q,   rd_perif_d;

  logic                ram_en;
  logic [DATA_W-1:0]   ram_rdata;
  logic [DATA_W-1:0]   sel_data;
  logic                ack_hit;

  // Only the selected window's ack and data slice are considered.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < int'(N_PERIPH); k++) begin
      if (cs_q[k]) sel_data = sel_data | i_data_perif[k*DATA_W +: DATA_W];
    end
    ack_hit = |(i_ack_perif & cs_q);
  end

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
    state_d      = state_q;
    region_d     = region_q;
    wr_d         = wr_q;
    err_d        = err_q;
    ram_addr_d   = ram_addr_q;
    wdata_d      = wdata_q;
    pdata_d      = pdata_q;
    cnt_d        = cnt_q;
    cs_d         = cs_q;
    addr_bus_d   = addr_bus_q;
    data_perif_d = data_perif_q;
    wr_perif_d   = wr_perif_q;
    rd_perif_d   = rd_perif_q;
    ram_en       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_rd ^ i_wr) begin
          region_d   = dec_region;
          wr_d       = i_wr;
          err_d      = 1'b0;
          ram_addr_d = i_addr[RAM_AW-1:0];
          wdata_d    = i_data;
          pdata_d    = '0;
          cnt_d      = '0;
          unique case (dec_region)
            REG_RAM:    state_d = RAM_ACC;
            REG_PERIPH: begin
              state_d      = PER_WAIT;
              cs_d         = dec_cs;
              addr_bus_d   = per_off[PA_W-1:0];
              data_perif_d = i_data;
              wr_perif_d   = i_wr;
              rd_perif_d   = i_rd;
            end
            default: begin
              state_d = RESP;
              err_d   = 1'b1;
            end
          endcase
        end
      end

      RAM_ACC: begin
        ram_en  = 1'b1;
        state_d = RESP;
      end

      PER_WAIT: begin
        if (ack_hit || (TIMEOUT_EN && cnt_q == CNT_W'(TIMEOUT))) begin
          state_d      = RESP;
          cs_d         = '0;
          addr_bus_d   = '0;
          data_perif_d = '0;
          wr_perif_d   = 1'b0;
          rd_perif_d   = 1'b0;
          if (ack_hit) begin
            if (!wr_q) pdata_d = sel_data;
          end else begin
            err_d = 1'b1;
          end
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q      <= IDLE;
      region_q     <= REG_RAM;
      wr_q         <= 1'b0;
      err_q        <= 1'b0;
      ram_addr_q   <= '0;
      wdata_q      <= '0;
      pdata_q      <= '0;
      cnt_q        <= '0;
      cs_q         <= '0;
      addr_bus_q   <= '0;
      data_perif_q <= '0;
      wr_perif_q   <= 1'b0;
      rd_perif_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      region_q     <= region_d;
      wr_q         <= wr_d;
      err_q        <= err_d;
      ram_addr_q   <= ram_addr_d;
      wdata_q      <= wdata_d;
      pdata_q      <= pdata_d;
      cnt_q        <= cnt_d;
      cs_q         <= cs_d;
      addr_bus_q   <= addr_bus_d;
      data_perif_q <= data_perif_d;
      wr_perif_q   <= wr_perif_d;
      rd_perif_q   <= rd_perif_d;
    end
  end

  data_ram #(
    .DATA_W    (DATA_W),
    .RAM_DEPTH (RAM_DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_data_ram (
    .i_clk   (i_clk),
    .i_en    (ram_en),
    .i_we    (wr_q),
    .i_addr  (ram_addr_q),
    .i_wdata (wdata_q),
    .o_rdata (ram_rdata)
  );

  // ---------------- outputs ----------------
  always_comb begin
    o_data = '0;
    if (state_q == RESP && !err_q && !wr_q) begin
      o_data = (region_q == REG_RAM) ? ram_rdata : pdata_q;
    end
  end

  assign o_ready      = (state_q == RESP);
  assign o_bus_err    = (state_q == RESP) && err_q;
  assign o_cs_perif   = cs_q;
  assign o_addr_bus   = addr_bus_q;
  assign o_data_perif = data_perif_q;
  assign o_wr_perif   = wr_perif_q;
  assign o_rd_perif   = rd_perif_q;

endmodule

// File: tb/tb_mem_io_bus.sv
// Self-checking bench for mem_io_bus: directed cases followed by randomized accesses
// against a map-level reference model (address arithmetic, RAM array, ack timing).
module tb_mem_io_bus;

  localparam int DATA_W       = 16;
  localparam int ADDR_W       = 12;
  localparam int RAM_DEPTH    = 1024;
  localparam int N_PERIPH     = 4;
  localparam int PERIPH_DEPTH = 64;
  localparam int PERIPH_BASE  = 2048;
  localparam int TIMEOUT      = 15;
  localparam int PA_W         = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       i_rst;
  logic [ADDR_W-1:0]          i_addr;
  logic [DATA_W-1:0]          i_data;
  logic                       i_wr;
  logic                       i_rd;
  logic [DATA_W-1:0]          o_data;
  logic                       o_ready;
  logic                       o_bus_err;
  logic [N_PERIPH-1:0]        o_cs_perif;
  logic [PA_W-1:0]            o_addr_bus;
  logic [DATA_W-1:0]          o_data_perif;
  logic                       o_wr_perif;
  logic                       o_rd_perif;
  logic [N_PERIPH*DATA_W-1:0] i_data_perif;
  logic [N_PERIPH-1:0]        i_ack_perif;

  mem_io_bus #(
    .DATA_W       (DATA_W),
    .ADDR_W       (ADDR_W),
    .RAM_DEPTH    (RAM_DEPTH),
    .N_PERIPH     (N_PERIPH),
    .PERIPH_DEPTH (PERIPH_DEPTH),
    .PERIPH_BASE  (PERIPH_BASE),
    .TIMEOUT      (TIMEOUT),
    .INIT_FILE    ("")
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_addr       (i_addr),
    .i_data       (i_data),
    .i_wr         (i_wr),
    .i_rd         (i_rd),
    .o_data       (o_data),
    .o_ready      (o_ready),
    .o_bus_err    (o_bus_err),
    .o_cs_perif   (o_cs_perif),
    .o_addr_bus   (o_addr_bus),
    .o_data_perif (o_data_perif),
    .o_wr_perif   (o_wr_perif),
    .o_rd_perif   (o_rd_perif),
    .i_data_perif (i_data_perif),
    .i_ack_perif  (i_ack_perif)
  );

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] ram_model [int];
  int                written [$];

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One full clock; outputs are then sampled and inputs driven at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // kind: 0 = RAM, 1 = peripheral window, 2 = unmapped.
  function automatic void decode(input int a, output int kind, output int win, output int off);
    win = 0;
    off = 0;
    if (a < RAM_DEPTH) begin
      kind = 0;
    end else if (a >= PERIPH_BASE && (a - PERIPH_BASE) / PERIPH_DEPTH < N_PERIPH) begin
      kind = 1;
      win  = (a - PERIPH_BASE) / PERIPH_DEPTH;
      off  = (a - PERIPH_BASE) % PERIPH_DEPTH;
    end else begin
      kind = 2;
    end
  endfunction

  // ack_at: wait-cycle index (0 = first PER_WAIT cycle) on which the peripheral acks, -1 = never.
  // stray:  0 = no other acks, 1 = random acks on other windows, 2 = all other windows ack.
  task automatic run_txn(input int addr, input bit wr, input logic [DATA_W-1:0] wdata,
                         input int ack_at, input int stray, input logic [DATA_W-1:0] pdata,
                         input string tag);
    int kind, win, off, lat, n;
    bit got, exp_err;
    logic [DATA_W-1:0]   exp_data;
    logic [N_PERIPH-1:0] sel;

    decode(addr, kind, win, off);
    sel      = N_PERIPH'(1) << win;
    exp_data = '0;
    exp_err  = 1'b0;
    case (kind)
      0: begin
        lat = 2;
        if (!wr) exp_data = ram_model[addr];
      end
      1: begin
        if (ack_at >= 0 && ack_at <= TIMEOUT) begin
          lat = ack_at + 2;
          if (!wr) exp_data = pdata;
        end else begin
          lat     = TIMEOUT + 2;
          exp_err = 1'b1;
        end
      end
      default: begin
        lat     = 1;
        exp_err = 1'b1;
      end
    endcase

    i_addr = ADDR_W'(addr);
    i_data = wdata;
    i_wr   = wr;
    i_rd   = !wr;
    n      = 0;
    got    = 1'b0;
    while (!got && n < TIMEOUT + 8) begin
      step();
      n++;
      if (o_ready) begin
        got = 1'b1;
      end else if (kind == 1) begin
        check($sformatf("%s cs", tag), 64'(o_cs_perif), 64'(sel));
        if (n == 1) begin
          check($sformatf("%s offset", tag), 64'(o_addr_bus), 64'(off));
          check($sformatf("%s strobes", tag), 64'({o_wr_perif, o_rd_perif}), 64'({wr, !wr}));
          check($sformatf("%s wdata", tag), 64'(o_data_perif), 64'(wdata));
        end
        i_ack_perif = '0;
        if (stray == 1) i_ack_perif = N_PERIPH'($urandom) & ~sel;
        if (stray == 2) i_ack_perif = ~sel;
        for (int k = 0; k < N_PERIPH; k++) i_data_perif[k*DATA_W +: DATA_W] = DATA_W'($urandom);
        if (n - 1 == ack_at) begin
          i_ack_perif[win]                    = 1'b1;
          i_data_perif[win*DATA_W +: DATA_W] = pdata;
        end
      end
    end

    check($sformatf("%s latency", tag), 64'(got ? n : 0), 64'(lat));
    if (got) begin
      check($sformatf("%s data", tag), 64'(o_data), 64'(exp_data));
      check($sformatf("%s err", tag), 64'(o_bus_err), 64'(exp_err));
      check($sformatf("%s idle outputs in resp", tag),
            64'({o_cs_perif, o_wr_perif, o_rd_perif}), 64'(0));
      if (kind == 0 && wr) begin
        ram_model[addr] = wdata;
        written.push_back(addr);
      end
    end

    i_wr        = 1'b0;
    i_rd        = 1'b0;
    i_ack_perif = '0;
    step();
    check($sformatf("%s ready drops", tag), 64'(o_ready), 64'(0));
    if (!got) begin
      i_rst = 1'b0;
      step();
      i_rst = 1'b1;
    end
  endtask

  initial begin
    int a, r, ack_at;
    bit wr;

    i_rst        = 1'b0;
    i_addr       = '0;
    i_data       = '0;
    i_wr         = 1'b0;
    i_rd         = 1'b0;
    i_data_perif = '0;
    i_ack_perif  = '0;

    // Reset state.
    step();
    step();
    check("reset ready/err", 64'({o_ready, o_bus_err}), 64'(0));
    check("reset data", 64'(o_data), 64'(0));
    check("reset cs/strobes", 64'({o_cs_perif, o_wr_perif, o_rd_perif}), 64'(0));
    check("reset periph bus", 64'({o_addr_bus, o_data_perif}), 64'(0));
    i_rst = 1'b1;
    step();

    // 1: RAM write then read.
    run_txn(5, 1'b1, 16'h1234, -1, 0, '0, "t1 write");
    run_txn(5, 1'b0, '0, -1, 0, '0, "t1 read");

    // 2: peripheral read, window 2 offset 3, ack on the fourth wait cycle.
    run_txn(PERIPH_BASE + 64*2 + 3, 1'b0, '0, 3, 1, 16'hBEEF, "t2 periph read");

    // 3: timeout on window 1 while every other window acks.
    run_txn(PERIPH_BASE + 64*1 + 7, 1'b0, '0, -1, 2, 16'h5A5A, "t3 timeout");

    // 4: unmapped address (window index 22).
    run_txn(3500, 1'b0, '0, -1, 0, '0, "t4 unmapped");

    // 5: reset in the middle of a peripheral wait.
    i_addr = ADDR_W'(PERIPH_BASE + 64*3 + 10);
    i_rd   = 1'b1;
    i_wr   = 1'b0;
    step();
    step();
    step();
    check("t5 cs before reset", 64'(o_cs_perif), 64'(4'b1000));
    i_rst = 1'b0;
    step();
    check("t5 cs/strobes at reset", 64'({o_cs_perif, o_wr_perif, o_rd_perif}), 64'(0));
    check("t5 no ready at reset", 64'(o_ready), 64'(0));
    i_rst = 1'b1;
    i_rd  = 1'b0;
    step();
    check("t5 no ready after reset", 64'(o_ready), 64'(0));
    run_txn(5, 1'b0, '0, -1, 0, '0, "t5 ram kept");

    // 6: both strobes high is a no-op.
    i_addr = ADDR_W'(5);
    i_rd   = 1'b1;
    i_wr   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t6 illegal op ready", 64'({o_ready, o_cs_perif, o_wr_perif, o_rd_perif}), 64'(0));
    end
    i_rd = 1'b0;
    i_wr = 1'b0;
    step();
    run_txn(5, 1'b0, '0, -1, 0, '0, "t6 idle after illegal");

    // Map and timing boundaries.
    run_txn(RAM_DEPTH - 1, 1'b1, 16'hCAFE, -1, 0, '0, "b ram last wr");
    run_txn(RAM_DEPTH - 1, 1'b0, '0, -1, 0, '0, "b ram last rd");
    run_txn(RAM_DEPTH, 1'b0, '0, -1, 0, '0, "b above ram");
    run_txn(PERIPH_BASE - 1, 1'b1, 16'h1111, -1, 0, '0, "b below periph");
    run_txn(PERIPH_BASE, 1'b0, '0, 0, 1, 16'h0F0F, "b window0 first ack0");
    run_txn(PERIPH_BASE + N_PERIPH*PERIPH_DEPTH - 1, 1'b1, 16'h7777, TIMEOUT, 1, '0, "b last window ack at limit");
    run_txn(PERIPH_BASE + 64 + 1, 1'b0, '0, TIMEOUT, 0, 16'h4242, "b read ack at limit");
    run_txn(PERIPH_BASE + 64 + 2, 1'b0, '0, TIMEOUT + 1, 0, 16'h4343, "b ack one late");
    run_txn(PERIPH_BASE + N_PERIPH*PERIPH_DEPTH, 1'b0, '0, -1, 0, '0, "b past last window");
    run_txn((1 << ADDR_W) - 1, 1'b1, 16'h9999, -1, 0, '0, "b top address");

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      r  = int'($urandom_range(0, 9));
      wr = 1'($urandom);
      ack_at = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 20));
      if (r < 4) begin
        if (!wr && written.size() > 0) a = written[$urandom_range(0, written.size() - 1)];
        else begin
          a  = int'($urandom_range(0, RAM_DEPTH - 1));
          wr = 1'b1;
        end
      end else if (r < 8) begin
        a = PERIPH_BASE + int'($urandom_range(0, N_PERIPH*PERIPH_DEPTH - 1));
      end else if (r == 8) begin
        a = int'($urandom_range(RAM_DEPTH, PERIPH_BASE - 1));
      end else begin
        a = int'($urandom_range(PERIPH_BASE + N_PERIPH*PERIPH_DEPTH, (1 << ADDR_W) - 1));
      end
      run_txn(a, wr, DATA_W'($urandom), ack_at, 1, DATA_W'($urandom), $sformatf("rand%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
